// File: rtl/tft_pattern_ctrl_pkg.sv
// Shared TFT definitions: RGB565 colours, panel geometry defaults, pattern codes.
package tft_pattern_ctrl_pkg;

  localparam int unsigned H_VALID_DEF = 480;
  localparam int unsigned V_VALID_DEF = 272;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GRAY   = 16'hD69A;

  typedef enum logic [2:0] {
    PAT_COLORBAR = 3'd0,
    PAT_HBARS    = 3'd1,
    PAT_CHECKER  = 3'd2,
    PAT_GRAD     = 3'd3,
    PAT_BORDER   = 3'd4
  } pat_e;

  // Colour of bar number idx in the shared bar palette.
  function automatic logic [15:0] bar_color(input logic [9:0] idx);
    case (idx)
      10'd0:   bar_color = RED;
      10'd1:   bar_color = ORANGE;
      10'd2:   bar_color = YELLOW;
      10'd3:   bar_color = GREEN;
      10'd4:   bar_color = CYAN;
      10'd5:   bar_color = BLUE;
      10'd6:   bar_color = PURPLE;
      10'd7:   bar_color = BLACK;
      10'd8:   bar_color = WHITE;
      10'd9:   bar_color = GRAY;
      default: bar_color = BLACK;
    endcase
  endfunction

  // Pattern sequence with wrap from BORDER back to COLORBAR.
  function automatic pat_e next_pat(input pat_e p);
    case (p)
      PAT_COLORBAR: next_pat = PAT_HBARS;
      PAT_HBARS:    next_pat = PAT_CHECKER;
      PAT_CHECKER:  next_pat = PAT_GRAD;
      PAT_GRAD:     next_pat = PAT_BORDER;
      default:      next_pat = PAT_COLORBAR;
    endcase
  endfunction

endpackage

// File: rtl/tft_pattern_ctrl_if.sv
// Pixel bus between the TFT timing generator and the pattern sequencer.
interface tft_pattern_ctrl_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;

  modport master (output pix_x, output pix_y, input pix_data, input frame_start);
  modport slave  (input pix_x, input pix_y, output pix_data, output frame_start);
endinterface

// File: rtl/tft_pattern_ctrl_gen.sv
// Combinational pattern generator: (pattern, pixel coordinate) -> RGB565 colour.
module tft_pattern_gen
  import tft_pattern_ctrl_pkg::*;
#(
  parameter int unsigned H_VALID = H_VALID_DEF,
  parameter int unsigned V_VALID = V_VALID_DEF
) (
  input  pat_e        pat,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] color
);

  logic [9:0] bar_x;
  logic [9:0] bar_y;
  logic       active;

  assign bar_x  = pix_x / 10'(H_VALID / 10);
  assign bar_y  = pix_y / 10'(V_VALID / 8);
  assign active = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));

  // Select the colour for the current pattern; blanking is always black.
  always_comb begin
    color = BLACK;
    if (active) begin
      case (pat)
        PAT_COLORBAR: color = bar_color(bar_x);
        PAT_HBARS:    color = bar_color(bar_y);
        PAT_CHECKER:  color = (pix_x[4] ^ pix_y[4]) ? BLACK : WHITE;
        PAT_GRAD:     color = {pix_x[8:4], 11'd0};
        PAT_BORDER:   color = (pix_x == 10'd0 || pix_x == 10'(H_VALID - 1) ||
                               pix_y == 10'd0 || pix_y == 10'(V_VALID - 1)) ? WHITE : BLACK;
        default:      color = BLACK;
      endcase
    end
  end

endmodule

// File: rtl/tft_pattern_ctrl.sv
// Test-pattern sequencer: frame detect, request/pending, auto frame timer,
// pattern FSM and registered pixel output.
module tft_pattern_ctrl
  import tft_pattern_ctrl_pkg::*;
#(
  parameter int unsigned H_VALID     = H_VALID_DEF,
  parameter int unsigned V_VALID     = V_VALID_DEF,
  parameter int unsigned AUTO_FRAMES = 120,
  parameter int unsigned FCNT_W      = 8
) (
  input  logic                   clk_9m,
  input  logic                   sys_rst,
  tft_pattern_ctrl_if.slave      pix_bus,
  input  logic                   key_next,
  input  logic                   auto_en,
  output logic [2:0]             pat_idx
);

  pat_e              pat_q;
  logic              pending;
  logic [FCNT_W-1:0] frame_cnt;
  logic              origin;
  logic              origin_d;
  logic              fs_q;
  logic [15:0]       pix_data_q;
  logic [15:0]       color;
  logic              expiry;
  logic              req;
  logic              apply;

  tft_pattern_gen #(
    .H_VALID (H_VALID),
    .V_VALID (V_VALID)
  ) u_gen (
    .pat   (pat_q),
    .pix_x (pix_bus.pix_x),
    .pix_y (pix_bus.pix_y),
    .color (color)
  );

  assign origin = (pix_bus.pix_x == 10'd0) && (pix_bus.pix_y == 10'd0);

  // A key and an expiry in the same cycle collapse into one request; a request
  // on the frame_start cycle itself is applied immediately.
  assign expiry = auto_en && fs_q && (frame_cnt == FCNT_W'(AUTO_FRAMES - 1));
  assign req    = key_next || expiry;
  assign apply  = fs_q && (pending || req);

  // Frame-start edge detect and 1-clk registered pixel output.
  always_ff @(posedge clk_9m) begin
    if (sys_rst) begin
      origin_d   <= 1'b0;
      fs_q       <= 1'b0;
      pix_data_q <= '0;
    end else begin
      origin_d   <= origin;
      fs_q       <= origin && !origin_d;
      pix_data_q <= color;
    end
  end

  // Pattern FSM with pending request and auto-advance frame counter.
  always_ff @(posedge clk_9m) begin
    if (sys_rst) begin
      pat_q     <= PAT_COLORBAR;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (apply) begin
        pat_q   <= next_pat(pat_q);
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end

      if (!auto_en || apply || key_next) begin
        frame_cnt <= '0;
      end else if (fs_q) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign pat_idx             = pat_q;
  assign pix_bus.pix_data    = pix_data_q;
  assign pix_bus.frame_start = fs_q;

endmodule

// File: tb/tb_tft_pattern_ctrl.sv
// Scoreboard bench for tft_pattern_ctrl: stimulus queues expected outputs
// tagged with the cycle they must appear in; a monitor checks them on negedge.
module tb_tft_pattern_ctrl;

  localparam int K_PIX = 0;
  localparam int K_PAT = 1;
  localparam int K_FS  = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic sys_rst;
  logic key_next;
  logic auto_en;
  logic [2:0] pat_idx;

  tft_pattern_ctrl_if bus ();

  tft_pattern_ctrl #(
    .AUTO_FRAMES (3),
    .FCNT_W      (8)
  ) dut (
    .clk_9m   (clk),
    .sys_rst  (sys_rst),
    .pix_bus  (bus),
    .key_next (key_next),
    .auto_en  (auto_en),
    .pat_idx  (pat_idx)
  );

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   tb_pat   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference colour model written from the pattern descriptions.
  function automatic logic [15:0] ref_pix(input int pat, input int x, input int y);
    logic [15:0] cols [10];
    cols = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
             16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};
    if (x >= 480 || y >= 272) return 16'h0000;
    case (pat)
      0: for (int i = 0; i < 10; i++) if (x >= 48 * i && x < 48 * (i + 1)) return cols[i];
      1: for (int i = 0; i < 8; i++) if (y >= 34 * i && y < 34 * (i + 1)) return cols[i];
      2: return (((x / 16) + (y / 16)) % 2 == 0) ? 16'hFFFF : 16'h0000;
      3: return 16'((x / 16) * 2048);
      4: return (x == 0 || x == 479 || y == 0 || y == 271) ? 16'hFFFF : 16'h0000;
      default: return 16'hxxxx;
    endcase
    return 16'hxxxx;
  endfunction

  task automatic push(input int c, input int k, input logic [15:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  // One pixel clock with the reference expectation for its output.
  task automatic step(input int x, input int y, input logic k);
    @(posedge clk);
    #1;
    sys_rst    = 1'b0;
    bus.pix_x  = 10'(x);
    bus.pix_y  = 10'(y);
    key_next   = k;
    push(cyc + 1, K_PIX, ref_pix(tb_pat, x, y));
  endtask

  // One pixel clock with a hand-computed expected colour.
  task automatic pixd(input int x, input int y, input logic [15:0] v);
    @(posedge clk);
    #1;
    sys_rst    = 1'b0;
    bus.pix_x  = 10'(x);
    bus.pix_y  = 10'(y);
    key_next   = 1'b0;
    push(cyc + 1, K_PIX, v);
  endtask

  task automatic rst_step(input int x, input int y);
    @(posedge clk);
    #1;
    sys_rst    = 1'b1;
    bus.pix_x  = 10'(x);
    bus.pix_y  = 10'(y);
    key_next   = 1'b0;
    push(cyc + 1, K_PIX, 16'h0000);
    push(cyc + 1, K_PAT, 16'd0);
    push(cyc + 1, K_FS,  16'd0);
  endtask

  // Frame boundary: origin, frame_start cycle (optionally with a key), two more pixels.
  task automatic frame(input logic k, input bit exp_apply);
    step(0, 0, 1'b0);
    push(cyc + 1, K_FS, 16'd1);
    step(1, 0, k);
    push(cyc + 1, K_FS, 16'd0);
    if (exp_apply) tb_pat = (tb_pat + 1) % 5;
    push(cyc + 1, K_PAT, 16'(tb_pat));
    step(2, 0, 1'b0);
    step(3, 1, 1'b0);
  endtask

  // Monitor: compare every queued expectation due in this cycle.
  always @(negedge clk) begin
    logic [15:0] act;
    string       nm;
    exp_t        e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_PIX:   begin act = bus.pix_data;            nm = "pix_data";    end
        K_PAT:   begin act = {13'd0, pat_idx};        nm = "pat_idx";     end
        default: begin act = {15'd0, bus.frame_start}; nm = "frame_start"; end
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d due=%0d actual=%h expected=%h", nm, cyc, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst   = 1'b1;
    key_next  = 1'b0;
    auto_en   = 1'b0;
    bus.pix_x = 10'h3FF;
    bus.pix_y = 10'h3FF;

    // Power-on reset
    for (int i = 0; i < 3; i++) rst_step(10'h3FF, 10'h3FF);
    step(10'h3FF, 10'h3FF, 1'b0);
    frame(1'b0, 1'b0);

    // Colour bar boundaries
    pixd(0,   10, 16'hF800);
    pixd(47,  10, 16'hF800);
    pixd(48,  10, 16'hFC00);
    pixd(479, 10, 16'hD69A);
    pixd(480, 10, 16'h0000);

    // Key mid-frame waits for the next frame boundary
    step(10, 100, 1'b1);
    push(cyc + 1, K_PAT, 16'd0);
    step(11, 100, 1'b0);
    frame(1'b0, 1'b1);
    // Two keys in one frame give a single step
    step(10, 100, 1'b1);
    step(11, 100, 1'b0);
    step(12, 101, 1'b1);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);

    // Pending request then mid-frame reset: reset wins, origin resyncs
    step(10, 100, 1'b1);
    step(100, 50, 1'b0);
    for (int i = 0; i < 3; i++) rst_step(100, 50);
    tb_pat = 0;
    step(100, 50, 1'b0);
    step(0, 0, 1'b0);
    push(cyc + 1, K_FS, 16'd1);
    step(0, 0, 1'b0);
    push(cyc + 1, K_FS, 16'd0);
    push(cyc + 1, K_PAT, 16'd0);
    step(5, 0, 1'b0);
    push(cyc + 1, K_FS, 16'd0);
    push(cyc + 1, K_PAT, 16'd0);

    // Auto advance every 3rd frame_start
    auto_en = 1'b1;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    // Key coinciding with expiry: single step, counter restarts
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b1);
    frame(1'b0, 1'b0);
    step(7, 7, 1'b0);
    auto_en = 1'b0;

    // Border pattern and wrap back to colour bars
    frame(1'b1, 1'b1);
    pixd(0,   5,   16'hFFFF);
    pixd(5,   5,   16'h0000);
    pixd(479, 5,   16'hFFFF);
    pixd(478, 271, 16'hFFFF);
    pixd(5,   270, 16'h0000);
    frame(1'b1, 1'b1);

    // Random coordinates against the reference model for every pattern
    for (int p = 0; p < 5; p++) begin
      if (tb_pat == 1) begin
        pixd(5, 33,  16'hF800);
        pixd(5, 34,  16'hFC00);
        pixd(5, 271, 16'h0000);
      end
      for (int i = 0; i < 40; i++) begin
        int x;
        int y;
        x = int'($urandom_range(0, 511));
        y = int'($urandom_range(0, 299));
        if (x == 0 && y == 0) y = 1;
        step(x, y, 1'b0);
      end
      pixd(10'h3FF, 10'h3FF, 16'h0000);
      pixd(10'h3FF, 5, 16'h0000);
      frame(1'b1, 1'b1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
